// File: rtl/fifo_read_interface.sv
// fifo_read_interface
//   Read-side controller of a FIFO. Owns the read pointer and the occupancy
//   count, decodes sig_Empty / sig_Full from the registered count, and returns
//   the popped entry one cycle after an accepted read, along with a one-cycle
//   read_Valid strobe. A read request while empty sets a sticky underflow flag.
// Ports
//   clock, reset          : single clock; asynchronous active-low reset
//   write_Enable          : raw producer request (qualified here against sig_Full)
//   read_Enable           : raw consumer request (qualified against sig_Empty)
//   read_Data_In          : storage-array word at read_Pointer (combinational)
//   read_Pointer          : address of the oldest unread entry
//   read_Data/read_Valid  : registered pop data and its strobe
//   sig_Empty/sig_Full    : occupancy flags, decoded from fill_Count only
//   fill_Count            : entries held, 0..DEPTH
//   underflow_Error       : sticky read-while-empty flag, cleared by reset only
module fifo_read_interface #(
  parameter int BUFFER_WIDTH = 3,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    write_Enable,
  input  logic                    read_Enable,
  input  logic [DATA_WIDTH-1:0]   read_Data_In,
  output logic [BUFFER_WIDTH-1:0] read_Pointer,
  output logic [DATA_WIDTH-1:0]   read_Data,
  output logic                    read_Valid,
  output logic                    sig_Empty,
  output logic                    sig_Full,
  output logic [BUFFER_WIDTH:0]   fill_Count,
  output logic                    underflow_Error
);

  localparam logic [BUFFER_WIDTH:0] DEPTH = {1'b1, {BUFFER_WIDTH{1'b0}}};

  logic [BUFFER_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [BUFFER_WIDTH:0]   count_q,  count_d;
  logic [DATA_WIDTH-1:0]   data_q,   data_d;
  logic                    valid_q,  valid_d;
  logic                    uflow_q,  uflow_d;
  logic                    fifo_write, fifo_read;

  // Flags come straight from the registered count, so qualification below
  // always sees the pre-edge state and there is no input-to-flag path.
  assign sig_Empty = (count_q == '0);
  assign sig_Full  = (count_q == DEPTH);

  // Must match the writer's own qualification exactly, or the count drifts.
  assign fifo_write = write_Enable & ~sig_Full;
  assign fifo_read  = read_Enable  & ~sig_Empty;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    data_d   = data_q;
    valid_d  = fifo_read;
    uflow_d  = uflow_q | (read_Enable & sig_Empty);

    if (fifo_read) begin
      rd_ptr_d = rd_ptr_q + 1'b1;      // natural wrap at 2**BUFFER_WIDTH
      data_d   = read_Data_In;         // word at the pre-increment pointer
    end

    unique case ({fifo_write, fifo_read})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;      // both or neither: occupancy unchanged
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      uflow_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      uflow_q  <= uflow_d;
    end
  end

  assign read_Pointer    = rd_ptr_q;
  assign fill_Count      = count_q;
  assign read_Data       = data_q;
  assign read_Valid      = valid_q;
  assign underflow_Error = uflow_q;

endmodule

// File: tb/tb_fifo_read_interface.sv
module tb_fifo_read_interface;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       write_Enable = 1'b0;
  logic       read_Enable  = 1'b0;
  logic [7:0] read_Data_In;
  logic [2:0] read_Pointer;
  logic [7:0] read_Data;
  logic       read_Valid, sig_Empty, sig_Full, underflow_Error;
  logic [3:0] fill_Count;

  fifo_read_interface #(.BUFFER_WIDTH(3), .DATA_WIDTH(8)) dut (
    .clock(clock), .reset(reset),
    .write_Enable(write_Enable), .read_Enable(read_Enable),
    .read_Data_In(read_Data_In), .read_Pointer(read_Pointer),
    .read_Data(read_Data), .read_Valid(read_Valid),
    .sig_Empty(sig_Empty), .sig_Full(sig_Full),
    .fill_Count(fill_Count), .underflow_Error(underflow_Error)
  );

  always #5 clock = ~clock;

  // Environment: storage array plus the write side, which qualifies its
  // writes with the same sig_Full the read controller exports.
  logic [7:0] mem [8];
  logic [2:0] wp;
  logic [7:0] wr_data = '0;
  assign read_Data_In = mem[read_Pointer];

  always @(posedge clock or negedge reset) begin
    if (!reset) wp <= '0;
    else if (write_Enable && !sig_Full) begin
      mem[wp] <= wr_data;
      wp      <= wp + 3'd1;
    end
  end

  // Reference model: a plain queue of stored entries.
  int         q[$];
  logic [2:0] m_ptr;
  logic [7:0] m_data;
  logic       m_valid, m_uf;
  int vectors = 0, miscompares = 0;

  function automatic logic [18:0] obs();
    return {read_Pointer, fill_Count, sig_Empty, sig_Full, read_Valid, read_Data, underflow_Error};
  endfunction

  function automatic logic [18:0] expv();
    logic [3:0] c;
    c = 4'(q.size());
    return {m_ptr, c, c == 4'd0, c == 4'd8, m_valid, m_data, m_uf};
  endfunction

  task automatic model_reset();
    q.delete();
    m_ptr = '0; m_data = '0; m_valid = 1'b0; m_uf = 1'b0;
  endtask

  // Apply one cycle of stimulus and advance the model; return #1 after the edge.
  task automatic step(input logic we, input logic re, input logic [7:0] wd);
    bit was_full, was_empty;
    write_Enable = we; read_Enable = re; wr_data = wd;
    @(posedge clock);
    was_full  = (q.size() == 8);
    was_empty = (q.size() == 0);
    m_valid = re && !was_empty;
    if (m_valid) begin
      m_data = 8'(q.pop_front());
      m_ptr  = m_ptr + 3'd1;
    end
    if (re && was_empty) m_uf = 1'b1;
    if (we && !was_full) q.push_back(int'(wd));
    #1;
    write_Enable = 1'b0; read_Enable = 1'b0;
  endtask

  task automatic test_reset();
    vectors++;
    if (obs() !== expv()) begin
      miscompares++;
      $display("FAIL reset_initial got=%h want=%h", obs(), expv());
    end
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(i + 8'h50));
    step(1'b1, 1'b1, 8'h55);          // mid-burst, count still 5
    #3 reset = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (obs() !== expv()) begin
      miscompares++;
      $display("FAIL reset_mid_burst got=%h want=%h", obs(), expv());
    end
    #2 reset = 1'b1;
    @(posedge clock); #1;
    vectors++;
    if (obs() !== expv()) begin
      miscompares++;
      $display("FAIL reset_release got=%h want=%h", obs(), expv());
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'hA0 + 8'(i));
    vectors++;
    if (sig_Full !== 1'b1 || fill_Count !== 4'd8) begin
      miscompares++;
      $display("FAIL fill_full got=%b/%0d want=1/8", sig_Full, fill_Count);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 8'h00);
      vectors++;
      if (read_Valid !== 1'b1 || read_Data !== 8'hA0 + 8'(i) || obs() !== expv()) begin
        miscompares++;
        $display("FAIL drain_%0d got=%h want=%h", i, obs(), expv());
      end
    end
    vectors++;
    if (sig_Empty !== 1'b1) begin
      miscompares++;
      $display("FAIL drain_empty got=%b want=1", sig_Empty);
    end
  endtask

  task automatic test_wrap();
    int nrd = 0;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h10 + 8'(i));
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < (r == 0 ? 4 : 6); i++) begin
        vectors++;
        if (read_Pointer !== 3'(nrd % 8)) begin
          miscompares++;
          $display("FAIL wrap_ptr_%0d got=%0d want=%0d", nrd, read_Pointer, nrd % 8);
        end
        step(1'b0, 1'b1, 8'h00);
        vectors++;
        if (obs() !== expv()) begin
          miscompares++;
          $display("FAIL wrap_read_%0d got=%h want=%h", nrd, obs(), expv());
        end
        nrd++;
      end
      if (r == 0) for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h18 + 8'(i));
    end
    while (q.size() != 0) step(1'b0, 1'b1, 8'h00);
  endtask

  task automatic test_full_both();
    logic [2:0] wp_before;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'($urandom));
    wp_before = wp;
    step(1'b1, 1'b1, 8'hEE);
    vectors++;
    if (fill_Count !== 4'd7 || read_Valid !== 1'b1 || sig_Full !== 1'b0 ||
        wp !== wp_before || obs() !== expv()) begin
      miscompares++;
      $display("FAIL full_both got=%h wp=%0d want=%h wp=%0d", obs(), wp, expv(), wp_before);
    end
    while (q.size() != 0) step(1'b0, 1'b1, 8'h00);
  endtask

  task automatic test_empty_both();
    step(1'b1, 1'b1, 8'h3C);
    vectors++;
    if (fill_Count !== 4'd1 || read_Valid !== 1'b0 || underflow_Error !== 1'b1 ||
        obs() !== expv()) begin
      miscompares++;
      $display("FAIL empty_both got=%h want=%h", obs(), expv());
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);
    vectors++;
    if (underflow_Error !== 1'b1) begin
      miscompares++;
      $display("FAIL underflow_sticky got=%b want=1", underflow_Error);
    end
  endtask

  task automatic test_count1_both();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 8'hC0 + 8'(i));
      vectors++;
      if (fill_Count !== 4'd1 || read_Valid !== 1'b1 || sig_Empty !== 1'b0 ||
          obs() !== expv()) begin
        miscompares++;
        $display("FAIL count1_both_%0d got=%h want=%h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50), 8'($urandom));
      vectors++;
      if (obs() !== expv()) begin
        miscompares++;
        $display("FAIL random_%0d got=%h want=%h", i, obs(), expv());
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = '0;
    model_reset();
    #12 reset = 1'b1;
    @(posedge clock); #1;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_full_both();
    test_empty_both();
    test_count1_both();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
